alu_ctrl_pipe: RTL and testbench

Registered, handshaked successor to the combinational ALU decoder, used by the pipelined/multi-cycle core between decode and execute. It decodes the full RV32I ALU operation set plus optional RV32M into a parametrised-width ALU control word. It holds that word in an output register under valid/ready flow control. Divide-class operations are sequenced with a fixed-latency busy counter so the execute stage can drive an iterative divider.

---
 rtl/alu_ctrl_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder with valid/ready output hold and fixed-latency divide sequencing.
// Optional RV32M decode, MDIV state, busy counter and o_busy are enabled by defining ALU_CTRL_M_EXT_EN.
module alu_ctrl_pipe #(
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_ALUOp,
  input  logic              i_op,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ALUControl,
  output logic              o_busy
);

  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] OP_ADD  = 5'd0;
  localparam logic [CODE_W-1:0] OP_SUB  = 5'd1;
  localparam logic [CODE_W-1:0] OP_AND  = 5'd2;
  localparam logic [CODE_W-1:0] OP_OR   = 5'd3;
  localparam logic [CODE_W-1:0] OP_XOR  = 5'd4;
  localparam logic [CODE_W-1:0] OP_SLT  = 5'd5;
  localparam logic [CODE_W-1:0] OP_SLTU = 5'd6;
  localparam logic [CODE_W-1:0] OP_SLL  = 5'd7;
  localparam logic [CODE_W-1:0] OP_SRL  = 5'd8;
  localparam logic [CODE_W-1:0] OP_SRA  = 5'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_MDIV = 2'd2
  } state_t;

  // Elaboration-time parameter sanity checks
  if (CTRL_W < CODE_W) begin : g_bad_ctrl_w
    $error("alu_ctrl_pipe: CTRL_W must be >= 5");
  end
  if (DIV_CYCLES < 2) begin : g_bad_div_cycles
    $error("alu_ctrl_pipe: DIV_CYCLES must be >= 2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] dec_code;
  logic              dec_div;
  logic              accept;

  // Combinational decode of the presented request
  always_comb begin
    dec_code = OP_ADD;
    dec_div  = 1'b0;
    case (i_ALUOp)
      2'b01: dec_code = OP_SUB;
      2'b10: begin
        case (i_funct3)
          3'b000:  dec_code = (i_op && i_funct7[5]) ? OP_SUB : OP_ADD;
          3'b001:  dec_code = OP_SLL;
          3'b010:  dec_code = OP_SLT;
          3'b011:  dec_code = OP_SLTU;
          3'b100:  dec_code = OP_XOR;
          3'b101:  dec_code = i_funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_code = OP_OR;
          default: dec_code = OP_AND;
        endcase
`ifdef ALU_CTRL_M_EXT_EN
        // mul..remu are contiguous codes in funct3 order
        if (i_op && (i_funct7 == 7'b0000001)) begin
          dec_code = 5'd10 + {2'b00, i_funct3};
          dec_div  = i_funct3[2];
        end
`endif
      end
      default: dec_code = OP_ADD;
    endcase
  end

  assign accept = i_valid & o_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ALU_CTRL_M_EXT_EN
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Divide latency counter: loads on divide accept, counts down in MDIV
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      cnt <= '0;
    end else if (accept && dec_div) begin
      cnt <= CNT_W'(DIV_CYCLES - 1);
    end else if ((state == S_MDIV) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
`else
  logic unused_funct7;
  assign unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};
`endif

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            state_nxt = dec_div ? S_MDIV : S_HOLD;
          end else if ((state == S_HOLD) && i_ready) begin
            state_nxt = S_IDLE;
          end
        end
`ifdef ALU_CTRL_M_EXT_EN
        S_MDIV: begin
          if (cnt == '0) begin
            state_nxt = S_HOLD;
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register; o_ready is the only combinational path
  always_comb begin
    o_valid = (state == S_HOLD);
`ifdef ALU_CTRL_M_EXT_EN
    o_busy  = (state == S_MDIV);
`else
    o_busy  = 1'b0;
`endif
    o_ready = i_rst_n & ~i_flush & (state != S_MDIV) & ((state != S_HOLD) | i_ready);
  end

  // Control word register, loaded only on accept
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ALUControl <= '0;
    end else if (accept) begin
      o_ALUControl <= CTRL_W'(dec_code);
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed self-checking bench for alu_ctrl_pipe (CTRL_W=6, DIV_CYCLES=4).
// Divide and flush-mid-divide scenarios run when ALU_CTRL_M_EXT_EN is defined.
module tb_alu_ctrl_pipe;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic         ready_o;
  logic [1:0]   aluop;
  logic         op_b;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         flush;
  logic         valid_o;
  logic         ready_in;
  logic [W-1:0] ctrl;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] a;
    logic       op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] code;
  } vec_t;

  vec_t vecs [14] = '{
    '{2'b10, 1'b1, 3'b000, 7'h00, 5'd0},
    '{2'b10, 1'b1, 3'b000, 7'h20, 5'd1},
    '{2'b10, 1'b0, 3'b000, 7'h20, 5'd0},
    '{2'b10, 1'b1, 3'b001, 7'h00, 5'd7},
    '{2'b10, 1'b1, 3'b010, 7'h00, 5'd5},
    '{2'b10, 1'b1, 3'b011, 7'h00, 5'd6},
    '{2'b10, 1'b1, 3'b100, 7'h00, 5'd4},
    '{2'b10, 1'b1, 3'b101, 7'h00, 5'd8},
    '{2'b10, 1'b1, 3'b101, 7'h20, 5'd9},
    '{2'b10, 1'b1, 3'b110, 7'h00, 5'd3},
    '{2'b10, 1'b1, 3'b111, 7'h00, 5'd2},
    '{2'b00, 1'b0, 3'b010, 7'h00, 5'd0},
    '{2'b01, 1'b0, 3'b000, 7'h00, 5'd1},
    '{2'b11, 1'b1, 3'b111, 7'h20, 5'd0}
  };

  alu_ctrl_pipe #(.CTRL_W(W), .DIV_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .o_ready      (ready_o),
    .i_ALUOp      (aluop),
    .i_op         (op_b),
    .i_funct3     (funct3),
    .i_funct7     (funct7),
    .i_flush      (flush),
    .o_valid      (valid_o),
    .i_ready      (ready_in),
    .o_ALUControl (ctrl),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [1:0] a, input logic op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic v);
    aluop = a; op_b = op; funct3 = f3; funct7 = f7; valid = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b100, 7'h00, 1'b1);
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready_comb got=%b exp=0", ready_o); end
    tick; tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_cmp++; if (ctrl !== W'(0)) begin n_err++; $display("FAIL reset_ctrl got=%0d exp=0", ctrl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    rst_n = 1'b1; valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%b exp=0", valid_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_base_sweep;
    ready_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_req(vecs[i].a, vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1);
      #1;
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL sweep_ready[%0d] got=%b exp=1", i, ready_o); end
      tick;
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL sweep_valid[%0d] got=%b exp=1", i, valid_o); end
      n_cmp++; if (ctrl !== W'(vecs[i].code)) begin n_err++; $display("FAIL sweep_code[%0d] got=%0d exp=%0d", i, ctrl, vecs[i].code); end
    end
    valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL sweep_drain_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_backpressure;
    ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b100, 7'h00, 1'b1);
    tick;
    n_cmp++; if (ctrl !== W'(4)) begin n_err++; $display("FAIL bp_xor_code got=%0d exp=4", ctrl); end
    ready_in = 1'b0;
    set_req(2'b10, 1'b1, 3'b111, 7'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, ready_o); end
      tick;
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, valid_o); end
      n_cmp++; if (ctrl !== W'(4)) begin n_err++; $display("FAIL bp_hold_code[%0d] got=%0d exp=4", i, ctrl); end
    end
    ready_in = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", ready_o); end
    tick;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_and_valid got=%b exp=1", valid_o); end
    n_cmp++; if (ctrl !== W'(2)) begin n_err++; $display("FAIL bp_and_code got=%0d exp=2", ctrl); end
    valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_flush_hold;
    ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b001, 7'h00, 1'b1);
    tick;
    n_cmp++; if (ctrl !== W'(7)) begin n_err++; $display("FAIL fh_sll_code got=%0d exp=7", ctrl); end
    ready_in = 1'b0; valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL fh_held_valid got=%b exp=1", valid_o); end
    flush = 1'b1;
    set_req(2'b10, 1'b1, 3'b110, 7'h00, 1'b1);
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL fh_ready_in_flush got=%b exp=0", ready_o); end
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL fh_flushed_valid got=%b exp=0", valid_o); end
    flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL fh_idle_valid got=%b exp=0", valid_o); end
  endtask

`ifdef ALU_CTRL_M_EXT_EN
  task automatic test_divide;
    ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b100, 7'h01, 1'b1);
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy_e got=%b exp=1", busy); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL div_valid_e got=%b exp=0", valid_o); end
    set_req(2'b10, 1'b1, 3'b000, 7'h00, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      #1;
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL div_ready[%0d] got=%b exp=0", j, ready_o); end
      tick;
      if (j < 4) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy[%0d] got=%b exp=1", j, busy); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL div_valid[%0d] got=%b exp=0", j, valid_o); end
      end else begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_done_busy got=%b exp=0", busy); end
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL div_done_valid got=%b exp=1", valid_o); end
        n_cmp++; if (ctrl !== W'(14)) begin n_err++; $display("FAIL div_code got=%0d exp=14", ctrl); end
      end
    end
    valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL div_drain_valid got=%b exp=0", valid_o); end
    set_req(2'b10, 1'b1, 3'b000, 7'h01, 1'b1);
    tick;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL mul_valid got=%b exp=1", valid_o); end
    n_cmp++; if (ctrl !== W'(10)) begin n_err++; $display("FAIL mul_code got=%0d exp=10", ctrl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mul_busy got=%b exp=0", busy); end
    valid = 1'b0;
    tick;
  endtask

  task automatic test_flush_divide;
    ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b101, 7'h01, 1'b1);
    tick;
    valid = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fd_busy_c2 got=%b exp=1", busy); end
    flush = 1'b1;
    set_req(2'b10, 1'b1, 3'b100, 7'h00, 1'b1);
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL fd_ready_in_flush got=%b exp=0", ready_o); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fd_busy got=%b exp=0", busy); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL fd_valid got=%b exp=0", valid_o); end
    flush = 1'b0;
    set_req(2'b10, 1'b1, 3'b110, 7'h00, 1'b1);
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL fd_next_ready got=%b exp=1", ready_o); end
    tick;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL fd_next_valid got=%b exp=1", valid_o); end
    n_cmp++; if (ctrl !== W'(3)) begin n_err++; $display("FAIL fd_next_code got=%0d exp=3", ctrl); end
    valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++; if ((valid_o !== 1'b0) || (busy !== 1'b0)) begin n_err++; $display("FAIL fd_quiet[%0d] got valid=%b busy=%b exp 0/0", k, valid_o, busy); end
    end
  endtask
`else
  task automatic test_macro_off;
    ready_in = 1'b1;
    set_req(2'b10, 1'b1, 3'b100, 7'h01, 1'b1);
    tick;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL noext_valid got=%b exp=1", valid_o); end
    n_cmp++; if (ctrl !== W'(4)) begin n_err++; $display("FAIL noext_xor_code got=%0d exp=4", ctrl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noext_busy got=%b exp=0", busy); end
    set_req(2'b10, 1'b1, 3'b000, 7'h01, 1'b1);
    tick;
    n_cmp++; if (ctrl !== W'(0)) begin n_err++; $display("FAIL noext_add_code got=%0d exp=0", ctrl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noext_busy2 got=%b exp=0", busy); end
    valid = 1'b0;
    tick;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL noext_drain got=%b exp=0", valid_o); end
  endtask
`endif

  initial begin
    test_reset;
    test_base_sweep;
    test_backpressure;
    test_flush_hold;
`ifdef ALU_CTRL_M_EXT_EN
    test_divide;
    test_flush_divide;
`else
    test_macro_off;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
